// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the byte-lane data memory.
// Little-endian: lane 0 holds bits [7:0] of a word.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_INIT = 2'b00;
  localparam logic [1:0] ST_IDLE = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_RESP = 2'b11;

  function automatic logic [3:0] lane_en(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    logic [3:0] en;
    case (size)
      SZ_BYTE: en = 4'b0001 << lane;
      SZ_HALF: en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  function automatic logic [31:0] wdata_rep(
    input logic [31:0] d,
    input logic [1:0]  size
  );
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(
    input logic [31:0] w,
    input logic [1:0]  size,
    input logic [1:0]  lane,
    input logic        uns
  );
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {lane, 3'b000};
    case (size)
      SZ_BYTE: r = uns ? {24'h0, sh[7:0]}
                       : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: r = uns ? {16'h0, sh[15:0]}
                       : {{16{sh[15]}}, sh[15:0]};
      SZ_WORD: r = w;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// DEPTH x 4 byte-lane synchronous RAM.
// Per-lane write enables; read data registered and held until next read.
module dmem_bytelane_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][i] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_bytelane_ctrl.sv
// Data memory controller: clear-after-reset, byte/half/word access,
// single outstanding request with RD_LAT-cycle load latency.
module dmem_bytelane_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    state;
  logic [AW-1:0] ptr;
  logic [1:0]    cnt;
  logic          init_q;
  logic          we_q;
  logic          err_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;

  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic          oor;
  logic          err;
  logic          accept;
  logic          in_init;

  logic [3:0]    ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  assign lane    = req_addr[1:0];
  assign idx     = req_addr[AW+1:2];
  assign oor     = |(req_addr >> (AW + 2));
  assign in_init = (state == ST_INIT);
  assign accept  = (state == ST_IDLE) & req_valid;

  always_comb begin
    err = oor;
    case (req_size)
      SZ_BYTE: ;
      SZ_HALF: if (lane[0]) err = 1'b1;
      SZ_WORD: if (lane != 2'b00) err = 1'b1;
      default: err = 1'b1;
    endcase
  end

  // Reset gates every array write, so a store on the reset edge is lost.
  always_comb begin
    ram_we = 4'b0000;
    if (rst_n) begin
      if (in_init) ram_we = 4'b1111;
      else if (accept & req_we & ~err)
        ram_we = lane_en(req_size, lane);
    end
  end

  assign ram_re    = rst_n & accept & ~req_we & ~err;
  assign ram_addr  = in_init ? ptr : idx;
  assign ram_wdata = in_init ? 32'h0
                             : wdata_rep(req_wdata, req_size);

  dmem_bytelane_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      ptr    <= '0;
      cnt    <= '0;
      init_q <= 1'b0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= 2'b00;
      lane_q <= 2'b00;
    end else begin
      case (state)
        ST_INIT: begin
          ptr <= ptr + AW'(1);
          if (ptr == AW'(DEPTH - 1)) begin
            state  <= ST_IDLE;
            init_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            err_q  <= err;
            uns_q  <= req_unsigned;
            size_q <= req_size;
            lane_q <= lane;
            if (err || req_we || RD_LAT == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= 2'(RD_LAT - 2);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 2'd0) state <= ST_RESP;
          else cnt <= cnt - 2'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign init_done  = init_q;

  assign resp_rdata = (resp_valid & ~err_q & ~we_q)
    ? load_extract(ram_rdata, size_q, lane_q, uns_q)
    : '0;

endmodule

// File: tb/tb_dmem_bytelane_ctrl.sv
// Directed bench for dmem_bytelane_ctrl with DEPTH=128, RD_LAT=3.
// Inputs driven and outputs sampled on the falling edge.
module tb_dmem_bytelane_ctrl;

  localparam int DEPTH  = 128;
  localparam int RD_LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  dmem_bytelane_ctrl #(
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Releases reset at a falling edge and walks the DEPTH-cycle clear.
  task automatic init_seq(input string tag);
    logic bad;
    bad = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      @(negedge clk);
      bad = bad | req_ready | init_done | resp_valid;
    end
    chk({tag, "_init_quiet"}, 32'(bad), 32'd0);
    @(negedge clk);
    chk({tag, "_init_done"},
        {30'd0, init_done, req_ready}, 32'd3);
    req_valid = 1'b0;
  endtask

  task automatic xfer(input string tag,
                      input logic we,
                      input logic [1:0] sz,
                      input logic uns,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [31:0] exp_d,
                      input logic exp_e);
    int n;
    int lat;
    logic rdy_bad;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    rdy_bad = 1'b0;
    while (!resp_valid && lat < 10) begin
      rdy_bad = rdy_bad | req_ready;
      @(negedge clk);
      lat++;
    end
    rdy_bad = rdy_bad | req_ready;
    chk({tag, "_lat"}, 32'(lat),
        (we || exp_e) ? 32'd1 : 32'(RD_LAT));
    chk({tag, "_data"}, resp_rdata, exp_d);
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_e));
    chk({tag, "_busy"}, 32'(rdy_bad), 32'd0);
    @(negedge clk);
    chk({tag, "_after"},
        {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    logic seen;
    rst_n        = 1'b0;
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h10;
    req_wdata    = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_outs",
        {27'd0, req_ready, resp_valid, resp_err,
         init_done, 1'b0}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);

    init_seq("boot");
    xfer("lw_10", 0, 2'b10, 0, 32'h10, 0, 32'h0, 0);

    xfer("sw_20", 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 0, 0);
    xfer("lb_20", 0, 2'b00, 0, 32'h20, 0, 32'h00000001, 0);
    xfer("lb_23", 0, 2'b00, 0, 32'h23, 0, 32'hFFFFFF80, 0);
    xfer("lbu_23", 0, 2'b00, 1, 32'h23, 0, 32'h00000080, 0);
    xfer("lh_22", 0, 2'b01, 0, 32'h22, 0, 32'hFFFF80FF, 0);
    xfer("lhu_20", 0, 2'b01, 1, 32'h20, 0, 32'h00007F01, 0);
    xfer("lw_20", 0, 2'b10, 0, 32'h20, 0, 32'h80FF7F01, 0);

    xfer("sw_40", 1, 2'b10, 0, 32'h40, 32'h11223344, 0, 0);
    xfer("sb_41", 1, 2'b00, 0, 32'h41, 32'h123456AA, 0, 0);
    xfer("sh_42", 1, 2'b01, 0, 32'h42, 32'hDEADBEEF, 0, 0);
    xfer("lw_40", 0, 2'b10, 0, 32'h40, 0, 32'hBEEFAA44, 0);

    xfer("lh_05", 0, 2'b01, 0, 32'h05, 0, 32'h0, 1);
    xfer("lw_06", 0, 2'b10, 0, 32'h06, 0, 32'h0, 1);
    xfer("sz11_08", 0, 2'b11, 0, 32'h08, 0, 32'h0, 1);
    xfer("lw_200", 0, 2'b10, 0, 32'h200, 0, 32'h0, 1);
    xfer("sw_41", 1, 2'b10, 0, 32'h41, 32'hFFFFFFFF, 0, 1);
    xfer("sb_200", 1, 2'b00, 0, 32'h200, 32'h55, 0, 1);
    xfer("sh_43", 1, 2'b01, 0, 32'h43, 32'h7777, 0, 1);
    xfer("lw_40b", 0, 2'b10, 0, 32'h40, 0, 32'hBEEFAA44, 0);
    xfer("lw_00", 0, 2'b10, 0, 32'h00, 0, 32'h0, 0);

    xfer("sw_1fc", 1, 2'b10, 0, 32'h1FC, 32'h0BADC0DE, 0, 0);
    xfer("lw_1fc", 0, 2'b10, 0, 32'h1FC, 0, 32'h0BADC0DE, 0);
    xfer("sw_60", 1, 2'b10, 0, 32'h60, 32'hCAFEF00D, 0, 0);
    xfer("lw_60", 0, 2'b10, 0, 32'h60, 0, 32'hCAFEF00D, 0);

    // Reset lands one cycle after a load accept.
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h60;
    chk("mid_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    seen      = resp_valid;
    repeat (4) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    chk("mid_no_resp", 32'(seen), 32'd0);
    chk("mid_rst_state",
        {30'd0, req_ready, init_done}, 32'd0);
    init_seq("rerun");
    xfer("lw_60z", 0, 2'b10, 0, 32'h60, 0, 32'h0, 0);
    xfer("lw_20z", 0, 2'b10, 0, 32'h20, 0, 32'h0, 0);
    xfer("lw_1fcz", 0, 2'b10, 0, 32'h1FC, 0, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane_ctrl.md
Name: dmem_bytelane_ctrl

Overview:
- Parametrised successor to the single-port word data memory in the MEM stage.
- Adds byte/halfword/word access with sign or zero extension and byte-lane write strobes, little-endian.
- Uses a valid/ready request channel with configurable read latency, and flags misaligned or out-of-range accesses.
- Hardware clears the array after reset, one word per cycle, instead of resetting every word in parallel.

Parameters:
- DATA_W, 32: word width in bits; must be 32 (sub-word decode is fixed to 4 lanes); kept as a parameter for the shared package.
- DEPTH, 128: number of words; power of two, at least 4.
- ADDR_W, 32: byte-address width of req_addr.
- RD_LAT, 1: cycles from read accept to resp_valid; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, out of range, or reserved size
- init_done  out  1  array clear complete

Behaviour:
- Reset is synchronous, active-low, and dominant over every other input.
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0, state=INIT, clear pointer=0.
- FSM states: INIT, IDLE, WAIT, RESP.
- INIT:
  - Writes 0 to word[ptr], ptr++.
  - After word DEPTH-1 is written: init_done=1, go to IDLE.
  - Lasts exactly DEPTH cycles after rst_n rises; req_ready=0 throughout.
- IDLE: req_ready=1. Accept occurs on a rising edge with req_valid & req_ready.
- Only one request is outstanding; req_ready=0 from the accept edge until the cycle after resp_valid.
- Address decode:
  - word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0].
  - Out of range when any req_addr bit at or above log2(DEPTH)+2 is set.
- Error conditions:
  - size 01 with addr[0]=1.
  - size 10 with addr[1:0]!=0.
  - size 11.
  - out of range.
  - On error: no array change. Go to RESP; resp_valid=1 and resp_err=1 on the cycle after accept, resp_rdata=0.
- Store, no error:
  - Write happens on the accept edge, updating only the enabled lanes.
  - Lane enables: byte → 1 lane at addr[1:0]; half → lanes {addr[1],0} and {addr[1],1}; word → all 4 lanes.
  - Data is replicated into the selected lanes.
  - Go to RESP; resp_valid=1 and resp_err=0 the next cycle, resp_rdata=0.
- Load, no error:
  - The array word is captured on the accept edge.
  - Go to WAIT for RD_LAT-1 cycles (skip WAIT if RD_LAT=1), then RESP.
  - In RESP: resp_valid=1, resp_rdata = selected lane(s), shifted down and sign- or zero-extended.
  - Latency from accept edge to resp_valid high = RD_LAT cycles.
- RESP lasts one cycle, then IDLE. The response has no backpressure; the consumer must take the pulse.
- Outside RESP: resp_valid=0, resp_err=0, resp_rdata=0.
- A load always sees the result of any earlier accepted store; this is guaranteed by the single-outstanding rule.
- Reset mid-operation (any state): the pending response is dropped and the array is cleared again through INIT. A store coinciding with the reset edge is not committed.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encodings.
  - a lane-enable function (size, addr[1:0] → 4-bit strobe).
  - a load-extract function (word, size, addr[1:0], unsigned → 32-bit result).
- One natural sub-module, dmem_bytelane_ram: DEPTH x 4 byte-lane synchronous RAM with per-lane write enable and registered read.
- The controller holds the FSM, clear pointer, latency counter and error decode.

Test Plan:
- Release rst_n, hold req_valid=1 → req_ready=0 for 128 cycles, init_done rises at cycle 128; a subsequent lw addr 0x10 returns 0x00000000, err=0.
- sw 0x80FF7F01 @0x20; then lb @0x20 → 0x00000001; lb @0x23 → 0xFFFFFF80; lbu @0x23 → 0x00000080; lh @0x22 → 0xFFFF80FF.
- sw 0x11223344 @0x40, sb 0xAA @0x41, sh 0xBEEF @0x42; lw @0x40 → 0xBEEFAA44.
- lh @0x05, lw @0x06, size=11 @0x08, lw @0x200 (DEPTH=128) → each gives resp_err=1, rdata=0; a following lw shows no memory change.
- RD_LAT=3: lw accepted at edge N → resp_valid only at edge N+3; req_ready low from N to N+3, high at N+4.
- Assert rst_n=0 one cycle after a load accept → no resp_valid; INIT re-runs for 128 cycles; previously stored data reads back as 0.
